// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the CPU-to-Wishbone data bridge: FSM state encoding,
// slave-index width helper and the read data returned on a failed access.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } bridge_state_t;

    // Value presented on cpu_rdata whenever an access fails.
    localparam int unsigned RDATA_ON_ERR = 0;

    // Number of top address bits used to pick a slave; at least one bit.
    function automatic int slv_bits(input int n_slaves);
        int bits;
        bits = $clog2(n_slaves);
        return (bits < 1) ? 1 : bits;
    endfunction

endpackage

// File: rtl/wb_addr_decoder.sv
// Slave decode for the data bridge: turns the top address field into a
// validity flag and a one-hot slave select.
module wb_addr_decoder
    import wb_bridge_pkg::*;
#(
    parameter int N_SLAVES = 2,
    localparam int SLV_BITS = slv_bits(N_SLAVES)
) (
    input  logic [SLV_BITS-1:0] field,
    output logic                valid,
    output logic [N_SLAVES-1:0] onehot
);

    // NOTE: every output gets a value before any branch so no latch is inferred.
    always_comb begin
        onehot = '0;
        valid  = (int'(field) < N_SLAVES);
        for (int k = 0; k < N_SLAVES; k++) begin
            onehot[k] = valid && (int'(field) == k);
        end
    end

endmodule

// File: rtl/wb_data_bridge.sv
// Bridges a stalling CPU data port onto a classic Wishbone bus with N_SLAVES
// one-hot selected slaves. Define WB_BRIDGE_TIMEOUT_EN to enable the ack timeout.
module wb_data_bridge
    import wb_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int N_SLAVES = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cpu_req,
    input  logic                       cpu_we,
    input  logic [ADDR_W-1:0]          cpu_adr,
    input  logic [DATA_W-1:0]          cpu_wdata,
    input  logic [DATA_W/8-1:0]        cpu_be,
    output logic [DATA_W-1:0]          cpu_rdata,
    output logic                       cpu_stall,
    output logic                       cpu_err,
    output logic                       wb_cyc_o,
    output logic                       wb_stb_o,
    output logic                       wb_we_o,
    output logic [ADDR_W-1:0]          wb_adr_o,
    output logic [DATA_W-1:0]          wb_dat_o,
    output logic [DATA_W/8-1:0]        wb_sel_o,
    output logic [N_SLAVES-1:0]        wb_ss_o,
    input  logic [N_SLAVES*DATA_W-1:0] wb_dat_i,
    input  logic [N_SLAVES-1:0]        wb_ack_i
);

    localparam int SLV_BITS = slv_bits(N_SLAVES);

    if (N_SLAVES < 1 || N_SLAVES > 8 || (DATA_W % 8) != 0 || TIMEOUT < 2) begin : g_param_check
        $error("wb_data_bridge: illegal parameter set");
    end

    bridge_state_t         state;
    logic                  dec_valid;
    logic [N_SLAVES-1:0]   dec_onehot;
    logic                  sel_ack;
    logic [DATA_W-1:0]     sel_rdata;

    wb_addr_decoder #(
        .N_SLAVES (N_SLAVES)
    ) u_addr_decoder (
        .field  (cpu_adr[ADDR_W-1 -: SLV_BITS]),
        .valid  (dec_valid),
        .onehot (dec_onehot)
    );

    // The registered select masks both ack and data, so other slaves are ignored.
    assign sel_ack = |(wb_ack_i & wb_ss_o);

    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < N_SLAVES; k++) begin
            if (wb_ss_o[k]) begin
                sel_rdata = sel_rdata | wb_dat_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign cpu_stall = cpu_req && (state != ST_RESP) && (state != ST_ERR);

`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] to_cnt;
    logic             to_expired;

    assign to_expired = (to_cnt == CNT_W'(TIMEOUT - 1));
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_ss_o   <= '0;
            wb_adr_o  <= '0;
            wb_dat_o  <= '0;
            wb_sel_o  <= '0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
`ifdef WB_BRIDGE_TIMEOUT_EN
            to_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if (dec_valid) begin
                            wb_adr_o <= cpu_adr;
                            wb_dat_o <= cpu_wdata;
                            wb_sel_o <= cpu_be;
                            wb_we_o  <= cpu_we;
                            wb_ss_o  <= dec_onehot;
                            wb_cyc_o <= 1'b1;
                            wb_stb_o <= 1'b1;
`ifdef WB_BRIDGE_TIMEOUT_EN
                            to_cnt   <= '0;
`endif
                            state    <= ST_BUS;
                        end else begin
                            cpu_err   <= 1'b1;
                            cpu_rdata <= DATA_W'(RDATA_ON_ERR);
                            state     <= ST_ERR;
                        end
                    end
                end

                ST_BUS: begin
                    if (sel_ack) begin
                        if (!wb_we_o) begin
                            cpu_rdata <= sel_rdata;
                        end
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        wb_ss_o  <= '0;
                        state    <= ST_RESP;
                    end
`ifdef WB_BRIDGE_TIMEOUT_EN
                    else if (to_expired) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_ss_o   <= '0;
                        cpu_err   <= 1'b1;
                        cpu_rdata <= DATA_W'(RDATA_ON_ERR);
                        state     <= ST_ERR;
                    end else begin
                        to_cnt <= to_cnt + CNT_W'(1);
                    end
`endif
                end

                ST_RESP: begin
                    state <= ST_IDLE;
                end

                ST_ERR: begin
                    cpu_err <= 1'b0;
                    state   <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_data_bridge.sv
// Randomized bench for wb_data_bridge: a 2-slave and a 3-slave instance checked
// against a transaction-level model of latency, selects, read data and errors.
module tb_wb_data_bridge;

    localparam int TO = 16;
`ifdef WB_BRIDGE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we, sel3;
    logic [31:0] cpu_adr, cpu_wdata;
    logic [3:0]  cpu_be;
    logic [2:0]  ack_v;
    logic [95:0] dat_v;

    logic [31:0] rdata2, adr2, dat2, rdata3, adr3, dat3;
    logic        stall2, err2, cyc2, stb2, we2, stall3, err3, cyc3, stb3, we3;
    logic [3:0]  sel2_o, sel3_o;
    logic [1:0]  ss2;
    logic [2:0]  ss3;

    logic [31:0] o_rdata, o_adr, o_dat;
    logic        o_stall, o_err, o_cyc, o_stb, o_we;
    logic [3:0]  o_sel;
    logic [2:0]  o_ss;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_rd2, exp_rd3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb_data_bridge #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(2), .TIMEOUT(TO)) dut2 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req & ~sel3), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(rdata2), .cpu_stall(stall2), .cpu_err(err2),
        .wb_cyc_o(cyc2), .wb_stb_o(stb2), .wb_we_o(we2),
        .wb_adr_o(adr2), .wb_dat_o(dat2), .wb_sel_o(sel2_o), .wb_ss_o(ss2),
        .wb_dat_i(dat_v[63:0]), .wb_ack_i(ack_v[1:0] & {2{~sel3}})
    );

    wb_data_bridge #(.ADDR_W(32), .DATA_W(32), .N_SLAVES(3), .TIMEOUT(TO)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req & sel3), .cpu_we(cpu_we), .cpu_adr(cpu_adr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_rdata(rdata3), .cpu_stall(stall3), .cpu_err(err3),
        .wb_cyc_o(cyc3), .wb_stb_o(stb3), .wb_we_o(we3),
        .wb_adr_o(adr3), .wb_dat_o(dat3), .wb_sel_o(sel3_o), .wb_ss_o(ss3),
        .wb_dat_i(dat_v), .wb_ack_i(ack_v & {3{sel3}})
    );

    assign o_rdata = sel3 ? rdata3 : rdata2;
    assign o_adr   = sel3 ? adr3   : adr2;
    assign o_dat   = sel3 ? dat3   : dat2;
    assign o_stall = sel3 ? stall3 : stall2;
    assign o_err   = sel3 ? err3   : err2;
    assign o_cyc   = sel3 ? cyc3   : cyc2;
    assign o_stb   = sel3 ? stb3   : stb2;
    assign o_we    = sel3 ? we3    : we2;
    assign o_sel   = sel3 ? sel3_o : sel2_o;
    assign o_ss    = sel3 ? ss3    : {1'b0, ss2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One CPU access. delay = BUS cycle index in which the slave acks (<0: never).
    task automatic access(input bit on3, input bit we, input logic [31:0] adr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input int delay, input logic [31:0] rword, input bit spur);
        int          nsl, sb, idx, exp_bus, exp_stall, bus_cnt, stall_cnt;
        bit          exp_err, done;
        logic [31:0] exp_rd;

        nsl = on3 ? 3 : 2;
        sb  = on3 ? 2 : 1;
        idx = int'(adr >> (32 - sb));
        if (idx >= nsl) begin
            exp_err = 1'b1; exp_bus = 0;
        end else if (TO_EN && (delay < 0 || delay >= TO)) begin
            exp_err = 1'b1; exp_bus = TO;
        end else begin
            exp_err = 1'b0; exp_bus = delay + 1;
        end
        exp_stall = exp_bus + 1;

        exp_rd = on3 ? exp_rd3 : exp_rd2;
        if (exp_err)  exp_rd = 32'h0;
        else if (!we) exp_rd = rword;
        if (on3) exp_rd3 = exp_rd;
        else     exp_rd2 = exp_rd;

        @(posedge clk); #1;
        sel3 = on3; cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wdata; cpu_be = be;
        bus_cnt = 0; stall_cnt = 0; done = 1'b0;

        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (!o_stall) begin
                done = 1'b1;
            end else begin
                stall_cnt++;
                if (o_cyc) begin
                    check("bus_stb", o_stb, 1);
                    check("bus_adr", o_adr, adr);
                    check("bus_dat", o_dat, wdata);
                    check("bus_sel", o_sel, be);
                    check("bus_we", o_we, we);
                    check("bus_ss", o_ss, 32'd1 << idx);
                    bus_cnt++;
                    dat_v = {$urandom, $urandom, $urandom};
                    ack_v = '0;
                    if (bus_cnt - 1 == delay) begin
                        ack_v[idx] = 1'b1;
                        dat_v[idx*32 +: 32] = rword;
                    end else if (spur) begin
                        ack_v[(idx + 1) % nsl] = 1'b1;
                    end
                    cpu_adr = $urandom; cpu_wdata = $urandom;
                    cpu_be = 4'($urandom); cpu_we = 1'($urandom);
                end
            end
        end

        check("completed", 32'(done), 1);
        check("stall_cycles", stall_cnt, exp_stall);
        check("bus_cycles", bus_cnt, exp_bus);
        check("err_pulse", o_err, exp_err);
        check("rdata", o_rdata, exp_rd);
        check("cyc_released", o_cyc, 0);
        check("ss_released", o_ss, 0);

        @(posedge clk); #1;
        cpu_req = 1'b0; ack_v = '0;
        @(negedge clk);
        check("err_one_cycle", o_err, 0);
        check("idle_cyc", o_cyc, 0);
        check("rdata_hold", o_rdata, exp_rd);
    endtask

    initial begin
        reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; sel3 = 1'b0;
        cpu_adr = '0; cpu_wdata = '0; cpu_be = '0; ack_v = '0; dat_v = '0;
        exp_rd2 = '0; exp_rd3 = '0;

        #12;
        check("rst_cyc", o_cyc, 0);
        check("rst_stb", o_stb, 0);
        check("rst_we", o_we, 0);
        check("rst_ss", o_ss, 0);
        check("rst_err", o_err, 0);
        check("rst_rdata", o_rdata, 0);
        check("rst_adr", o_adr, 0);
        check("rst_dat", o_dat, 0);
        check("rst_sel", o_sel, 0);
        check("rst_cyc3", cyc3, 0);
        @(negedge clk); reset = 1'b1;

        // Directed cases.
        access(0, 0, 32'h0000_0010, 32'h0000_0000, 4'hF, 2, 32'h1234_5678, 0);
        access(0, 1, 32'h8000_0004, 32'hCAFE_F00D, 4'b0011, 1, 32'hDEAD_BEEF, 0);
        access(1, 0, 32'hC000_0000, 32'h1111_1111, 4'hF, 0, 32'h5555_AAAA, 0);
        access(1, 0, 32'h8000_0008, 32'h0, 4'hF, 0, 32'h0BAD_CAFE, 0);
        access(0, 0, 32'h0000_0020, 32'h0, 4'hF, TO_EN ? -1 : 40, 32'h7777_0000, 0);
        access(0, 0, 32'h0000_0030, 32'h0, 4'hF, 4, 32'hA5A5_5A5A, 1);
        access(1, 1, 32'h4000_0100, 32'h0123_4567, 4'b1100, 3, 32'hFFFF_0000, 1);

        // Randomized traffic on both instances.
        for (int i = 0; i < 40; i++) begin
            access(1'($urandom), 1'($urandom), $urandom, $urandom, 4'($urandom),
                   int'($urandom_range(0, 6)), $urandom, 1'($urandom));
        end

        // Reset in the third BUS cycle of a read, then a late ack.
        @(posedge clk); #1;
        sel3 = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h0000_0040; cpu_be = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("pre_reset_cyc", o_cyc, 1);
        #2 reset = 1'b0;
        #1;
        check("mid_reset_cyc", o_cyc, 0);
        check("mid_reset_stb", o_stb, 0);
        check("mid_reset_ss", o_ss, 0);
        check("mid_reset_rdata", o_rdata, 0);
        exp_rd2 = '0;
        cpu_req = 1'b0;
        @(negedge clk); reset = 1'b1;
        ack_v = 3'b001; dat_v = {$urandom, $urandom, $urandom};
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("late_ack_cyc", o_cyc, 0);
            check("late_ack_rdata", o_rdata, 0);
            check("late_ack_err", o_err, 0);
        end
        ack_v = '0;
        access(0, 0, 32'h8000_0044, 32'h0, 4'hF, 1, 32'h600D_D00D, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/wb_data_bridge.md
WB_DATA_BRIDGE -- requirements
Module: wb_data_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the CPU/bus address width.
REQ-002 SHALL have parameter DATA_W, default 32, the data width, a multiple of 8.
REQ-003 SHALL have parameter N_SLAVES, default 2, the number of Wishbone slaves, range 1..8.
REQ-004 SHALL have parameter TIMEOUT, default 16, the maximum BUS cycles waiting for ack, minimum 2.
REQ-005 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  data access request.
- cpu_we  in  1  1 = write.
- cpu_adr  in  ADDR_W  byte address.
- cpu_wdata  in  DATA_W  write data.
- cpu_be  in  DATA_W/8  byte enables.
- cpu_rdata  out  DATA_W  read data.
- cpu_stall  out  1  CPU holds PC and request.
- cpu_err  out  1  access-failed pulse.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone classic strobes.
- wb_adr_o  out  ADDR_W  registered address.
- wb_dat_o  out  DATA_W  registered write data.
- wb_sel_o  out  DATA_W/8  registered byte selects.
- wb_ss_o  out  N_SLAVES  one-hot slave select.
- wb_dat_i  in  N_SLAVES*DATA_W  slave read data, slave k at slice k.
- wb_ack_i  in  N_SLAVES  per-slave ack.

Function
REQ-006 SHALL implement an FSM with states IDLE, BUS, RESP and ERR.
REQ-007 SHALL compute the slave index from the top SLV_BITS = max(1, clog2(N_SLAVES)) bits of cpu_adr.
REQ-008 SHALL, in IDLE with cpu_req=1 and a valid index, register adr, wdata, be, we and the one-hot select, then enter BUS.
REQ-009 SHALL, in IDLE with cpu_req=1 and index >= N_SLAVES, enter ERR without asserting wb_cyc_o.
REQ-010 SHALL assert wb_cyc_o and wb_stb_o only in BUS, with wb_ss_o one-hot; wb_ss_o SHALL be all-zero otherwise.
REQ-011 SHALL, in BUS, respond only to the selected slave's ack; acks from other slaves are ignored.
REQ-012 SHALL, on the selected ack, capture the selected slice of wb_dat_i into cpu_rdata on reads, hold cpu_rdata on writes, and enter RESP.
REQ-013 SHALL drive cpu_stall = cpu_req && state != RESP && state != ERR; a granted access therefore completes no earlier than 2 cycles after the request, ack-to-release is 1 cycle, and the minimum access is 3 cycles.
REQ-014 SHALL remain in RESP and ERR for exactly one cycle, then return to IDLE; back-to-back requests are not accepted in RESP or ERR.
REQ-015 SHALL pulse cpu_err for one cycle in ERR and SHALL force cpu_rdata to 0 in ERR.
REQ-016 SHALL hold the registered outputs stable throughout BUS regardless of changes on the CPU inputs.

Reset
REQ-017 SHALL, on reset low, immediately (asynchronously) enter IDLE and clear wb_cyc_o, wb_stb_o, wb_we_o, wb_ss_o, cpu_err, cpu_rdata, wb_adr_o, wb_dat_o, wb_sel_o and the timeout counter.
REQ-018 SHALL, on reset mid-BUS, abandon the cycle; a late ack after reset release SHALL be ignored in IDLE.

Configuration
REQ-019 SHALL, with WB_BRIDGE_TIMEOUT_EN defined, count BUS cycles; if TIMEOUT cycles elapse without the selected ack, it SHALL drop wb_cyc_o/wb_stb_o and enter ERR.
REQ-020 SHALL, without WB_BRIDGE_TIMEOUT_EN, contain no counter and wait in BUS indefinitely; ERR is then reachable only by an invalid index.

Structure
REQ-021 SHALL take the FSM state enum, SLV_BITS computation and the read-on-error value 0 from the shared package wb_bridge_pkg.
REQ-022 SHALL place index decode and one-hot generation in the sub-module wb_addr_decoder.

Verification
REQ-023 The bench SHALL cover: read 0x0000_0010 on slave 0 acking 2 cycles after stb -> cpu_rdata=0x1234_5678, stall released 1 cycle after ack.
REQ-024 The bench SHALL cover: write 0x8000_0004 with be=4'b0011 on slave 1 -> wb_sel_o=0011, wb_ss_o=2'b10, wb_we_o=1, cpu_err=0.
REQ-025 The bench SHALL cover: N_SLAVES=3, access 0xC000_0000 -> no wb_cyc_o, cpu_err pulses once, cpu_rdata=0.
REQ-026 The bench SHALL cover: with WB_BRIDGE_TIMEOUT_EN and TIMEOUT=16, a slave that never acks -> cyc drops after 16 BUS cycles and cpu_err=1 for one cycle.
REQ-027 The bench SHALL cover: a slave-1 ack during a slave-0 access -> ignored, FSM stays in BUS.
REQ-028 The bench SHALL cover: reset asserted in BUS cycle 3 -> wb_cyc_o=0 within the same cycle, and a late ack after release has no effect.
